// File: rtl/pipe_stage_buf_pkg.sv
// Shared definitions for the inter-stage pipeline buffers: boundary widths,
// EX/MEM field layout, bubble constants and a pointer-wrap helper.
package pipe_pkg;

    // Bundle widths of each stage boundary.
    localparam int IF_ID_W  = 64;
    localparam int ID_EX_W  = 148;
    localparam int EX_MEM_W = 112;
    localparam int MEM_WB_W = 104;

    // EX/MEM field positions, MSB-first numbering [0:EX_MEM_W-1].
    localparam int EXM_NEXTPC_LO     = 0;
    localparam int EXM_NEXTPC_HI     = 31;
    localparam int EXM_OPB_LO        = 32;
    localparam int EXM_OPB_HI        = 63;
    localparam int EXM_DESTREG_LO    = 64;
    localparam int EXM_DESTREG_HI    = 68;
    localparam int EXM_ALURESULT_LO  = 69;
    localparam int EXM_ALURESULT_HI  = 100;
    localparam int EXM_PCTOREG       = 101;
    localparam int EXM_REGTOPC       = 102;
    localparam int EXM_JUMP          = 103;
    localparam int EXM_BRANCH        = 104;
    localparam int EXM_BRANCHZERO    = 105;
    localparam int EXM_REGWRITE      = 106;
    localparam int EXM_MEMTOREG      = 107;
    localparam int EXM_MEMWRITE      = 108;
    localparam int EXM_LOADSIGN      = 109;
    localparam int EXM_DSIZE_LO      = 110;
    localparam int EXM_DSIZE_HI      = 111;

    // Default bubbles: every control bit deasserted, so the word acts as a NOP.
    localparam logic [0:IF_ID_W-1]  IF_ID_BUBBLE  = {IF_ID_W{1'b0}};
    localparam logic [0:ID_EX_W-1]  ID_EX_BUBBLE  = {ID_EX_W{1'b0}};
    localparam logic [0:EX_MEM_W-1] EX_MEM_BUBBLE = {EX_MEM_W{1'b0}};
    localparam logic [0:MEM_WB_W-1] MEM_WB_BUBBLE = {MEM_WB_W{1'b0}};

    // What the buffer does to its occupancy this cycle ({push, pop}).
    typedef enum logic [1:0] {
        OP_IDLE = 2'b00,
        OP_POP  = 2'b01,
        OP_PUSH = 2'b10,
        OP_BOTH = 2'b11
    } buf_op_e;

    // Advance a circular pointer; depth need not be a power of two.
    function automatic logic [31:0] wrap_inc(input logic [31:0] ptr, input int unsigned depth);
        logic [31:0] last;
        last = depth - 32'd1;
        if (ptr == last) begin
            return 32'd0;
        end else begin
            return ptr + 32'd1;
        end
    endfunction

endpackage

// File: rtl/pipe_stage_buf_if.sv
// Upstream/downstream valid-ready handshake bundle of one pipeline buffer.
// The slave view belongs to the buffer, the master view to its environment.
interface pipe_stage_buf_if import pipe_pkg::*; #(
    parameter int WIDTH = EX_MEM_W
);
    logic             in_valid;
    logic             in_ready;
    logic [0:WIDTH-1] in_data;
    logic             out_valid;
    logic             out_ready;
    logic [0:WIDTH-1] out_data;

    modport master (
        output in_valid, in_data, out_ready,
        input  in_ready, out_valid, out_data
    );

    modport slave (
        input  in_valid, in_data, out_ready,
        output in_ready, out_valid, out_data
    );
endinterface

// File: rtl/pipe_stage_buf.sv
// Pipeline stage buffer: DEPTH-entry circular skid store with valid/ready on
// both sides, flush with bubble insertion and a saturating stall counter.
// All outputs come straight from registers; the next head word is computed
// ahead of the edge so out_data never depends combinationally on the inputs.
module pipe_stage_buf import pipe_pkg::*; #(
    parameter int               WIDTH  = EX_MEM_W,
    parameter int               DEPTH  = 2,
    parameter logic [0:WIDTH-1] BUBBLE = {WIDTH{1'b0}}
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       flush,
    pipe_stage_buf_if.slave            bus,
    output logic [$clog2(DEPTH+1)-1:0] count,
    output logic [15:0]                stall_cycles
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = $clog2(DEPTH + 1);

    logic [0:WIDTH-1] mem_r [DEPTH];
    logic [PTR_W-1:0] rd_ptr_r;
    logic [PTR_W-1:0] wr_ptr_r;
    logic [CNT_W-1:0] count_r;
    logic             out_valid_r;
    logic             in_ready_r;
    logic [0:WIDTH-1] out_data_r;
    logic [15:0]      stall_r;

    logic             push_s;
    logic             pop_s;
    buf_op_e          op_s;
    logic [PTR_W-1:0] rd_ptr_nxt_s;
    logic [PTR_W-1:0] wr_ptr_nxt_s;
    logic [PTR_W-1:0] rd_ptr_inc_s;
    logic [PTR_W-1:0] wr_ptr_inc_s;
    logic [CNT_W-1:0] count_nxt_s;
    logic [0:WIDTH-1] out_data_nxt_s;

    assign push_s = bus.in_valid && in_ready_r && !flush;
    assign pop_s  = out_valid_r && bus.out_ready && !flush;
    assign op_s   = buf_op_e'({push_s, pop_s});

    assign rd_ptr_inc_s = PTR_W'(wrap_inc(32'(rd_ptr_r), DEPTH));
    assign wr_ptr_inc_s = PTR_W'(wrap_inc(32'(wr_ptr_r), DEPTH));

    // Next pointers and occupancy; flush wins over any push or pop.
    always_comb begin
        rd_ptr_nxt_s = rd_ptr_r;
        wr_ptr_nxt_s = wr_ptr_r;
        count_nxt_s  = count_r;
        if (flush) begin
            rd_ptr_nxt_s = {PTR_W{1'b0}};
            wr_ptr_nxt_s = {PTR_W{1'b0}};
            count_nxt_s  = {CNT_W{1'b0}};
        end else begin
            case (op_s)
                OP_PUSH: begin
                    wr_ptr_nxt_s = wr_ptr_inc_s;
                    count_nxt_s  = count_r + CNT_W'(1);
                end
                OP_POP: begin
                    rd_ptr_nxt_s = rd_ptr_inc_s;
                    count_nxt_s  = count_r - CNT_W'(1);
                end
                OP_BOTH: begin
                    rd_ptr_nxt_s = rd_ptr_inc_s;
                    wr_ptr_nxt_s = wr_ptr_inc_s;
                end
                OP_IDLE: begin
                    count_nxt_s = count_r;
                end
                default: begin
                    count_nxt_s = count_r;
                end
            endcase
        end
    end

    // Head word for next cycle: bubble when empty, the incoming word when it
    // lands directly at the new head slot, otherwise the stored entry.
    always_comb begin
        out_data_nxt_s = BUBBLE;
        if (count_nxt_s == {CNT_W{1'b0}}) begin
            out_data_nxt_s = BUBBLE;
        end else if (push_s && (wr_ptr_r == rd_ptr_nxt_s)) begin
            out_data_nxt_s = bus.in_data;
        end else begin
            out_data_nxt_s = mem_r[rd_ptr_nxt_s];
        end
    end

    // Entry storage; contents carry no reset value.
    always_ff @(posedge clk) begin
        if (!reset && push_s) begin
            mem_r[wr_ptr_r] <= bus.in_data;
        end
    end

    // Control state, registered outputs and the saturating stall counter.
    always_ff @(posedge clk) begin
        if (reset) begin
            rd_ptr_r    <= {PTR_W{1'b0}};
            wr_ptr_r    <= {PTR_W{1'b0}};
            count_r     <= {CNT_W{1'b0}};
            out_valid_r <= 1'b0;
            in_ready_r  <= 1'b1;
            out_data_r  <= BUBBLE;
            stall_r     <= 16'h0000;
        end else begin
            rd_ptr_r    <= rd_ptr_nxt_s;
            wr_ptr_r    <= wr_ptr_nxt_s;
            count_r     <= count_nxt_s;
            out_valid_r <= (count_nxt_s != {CNT_W{1'b0}});
            in_ready_r  <= (count_nxt_s < CNT_W'(DEPTH));
            out_data_r  <= out_data_nxt_s;
            if (out_valid_r && !bus.out_ready && (stall_r != 16'hFFFF)) begin
                stall_r <= stall_r + 16'd1;
            end
        end
    end

    assign bus.in_ready  = in_ready_r;
    assign bus.out_valid = out_valid_r;
    assign bus.out_data  = out_data_r;
    assign count         = count_r;
    assign stall_cycles  = stall_r;

endmodule
